// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch path.
package imem_fetch_ctrl_pkg;

  // Encoding of "addi x0, x0, 0", returned for fetches outside the SRAM.
  localparam logic [31:0] ImemNop = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] ir;
  } imem_rsp_t;

endpackage

// File: rtl/ifetch_if_t.sv
// Fetch request/response channel pair between core front-end and fetch controller.
interface ifetch_if_t #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          req_vld;
  logic          req_rdy;
  logic [AW-1:0] req_pc;
  logic          rsp_vld;
  logic          rsp_rdy;
  logic [DW-1:0] rsp_ir;

  modport slave (
    input  req_vld, req_pc, rsp_rdy,
    output req_rdy, rsp_vld, rsp_ir
  );

  modport master (
    output req_vld, req_pc, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_ir
  );
endinterface

// File: rtl/resp_fifo2.sv
// Two-entry response FIFO with same-cycle push/pop and register-backed head.
module resp_fifo2 #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          empty,
  output logic          full,
  output logic [1:0]    count
);

  logic [DW-1:0] mem_q [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push & (~full_q | pop);
  assign do_pop  = pop & ~empty_q;

  // Pointer and full/empty flag next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    full_d   = full_q;
    empty_d  = empty_q;
    if (do_push && !do_pop) begin
      empty_d = 1'b0;
      full_d  = (wr_ptr_d == rd_ptr_q);
    end else if (do_pop && !do_push) begin
      full_d  = 1'b0;
      empty_d = (rd_ptr_d == wr_ptr_q);
    end
  end

  // Storage and pointer registers; when full, the write lands in the slot being popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Status and head outputs.
  always_comb begin
    head  = mem_q[rd_ptr_q];
    empty = empty_q;
    full  = full_q;
    count = full_q ? 2'd2 : (empty_q ? 2'd0 : 2'd1);
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: one-cycle SRAM read with in-order, 2-deep response buffering.
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ifetch_if_t.slave                ifetch,
  output logic                     mem_cs,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  input  logic [DW-1:0]            mem_rdata
);

  localparam int unsigned AddrW  = $clog2(DEPTH);
  localparam imem_rsp_t   NopRsp = '{ir: ImemNop};
  localparam logic [DW-1:0] NopIr = DW'(NopRsp.ir);

  logic [AW-3:0] word_idx;
  logic [1:0]    unused_pc_lo;
  logic          in_range;
  logic          inflight_q, inflight_d;
  logic          oor_q, oor_d;
  logic          req_hs, rsp_hs;
  logic [1:0]    occupancy;
  logic [DW-1:0] rd_data;
  logic          fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [1:0]    fifo_count;
  logic [DW-1:0] fifo_head;

  assign word_idx     = ifetch.req_pc[AW-1:2];
  assign unused_pc_lo = ifetch.req_pc[1:0];
  assign in_range     = ((word_idx >> AddrW) == '0);

  // Response path: flow-through from the SRAM when nothing older is queued.
  assign rd_data        = oor_q ? NopIr : mem_rdata;
  assign ifetch.rsp_vld = inflight_q | ~fifo_empty;
  assign ifetch.rsp_ir  = (fifo_empty & inflight_q) ? rd_data : fifo_head;
  assign rsp_hs         = ifetch.rsp_vld & ifetch.rsp_rdy;

  // Ready depends only on state and rsp_rdy, never on req_vld; forced low in reset.
  assign occupancy      = {1'b0, inflight_q} + fifo_count;
  assign ifetch.req_rdy = rst_n & ((occupancy < 2'd2) | rsp_hs);
  assign req_hs         = ifetch.req_vld & ifetch.req_rdy;

  // SRAM request, FIFO control and in-flight tracking.
  always_comb begin
    mem_cs     = req_hs & in_range;
    mem_addr   = mem_cs ? word_idx[AddrW-1:0] : '0;
    fifo_pop   = rsp_hs & ~fifo_empty;
    // Buffer the returning word unless it is consumed directly this cycle.
    fifo_push  = inflight_q & ~(fifo_empty & ifetch.rsp_rdy);
    inflight_d = req_hs;
    oor_d      = req_hs & ~in_range;
  end

  // In-flight read register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      oor_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      oor_q      <= oor_d;
    end
  end

  resp_fifo2 #(
    .DW (DW)
  ) u_resp_fifo2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (rd_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  logic unused_fifo_full;
  assign unused_fifo_full = fifo_full;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl with an SRAM model and response scoreboard.
module tb_imem_fetch_ctrl;
  import imem_fetch_ctrl_pkg::*;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AddrW = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             mem_cs;
  logic [AddrW-1:0] mem_addr;
  logic [DW-1:0]    mem_rdata;

  ifetch_if_t #(.AW(AW), .DW(DW)) bus ();

  imem_fetch_ctrl #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ifetch    (bus.slave),
    .mem_cs    (mem_cs),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model: data valid the cycle after mem_cs, garbage otherwise.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_cs) mem_rdata <= mem[mem_addr];
    else        mem_rdata <= $urandom;
  end

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_ir;

  function automatic logic [DW-1:0] model_ir(input logic [AW-1:0] pc);
    if ((pc >> 2) < DEPTH) return mem[pc[AddrW+1:2]];
    return ImemNop;
  endfunction

  task automatic drive(input logic vld, input logic [AW-1:0] pc, input logic rdy);
    @(posedge clk);
    #1;
    bus.req_vld = vld;
    bus.req_pc  = pc;
    bus.rsp_rdy = rdy;
  endtask

  // Scoreboard push: record the expected word for an accepted request.
  task automatic note_req();
    if (bus.req_vld && bus.req_rdy) exp_q.push_back(model_ir(bus.req_pc));
  endtask

  task automatic test_reset();
    bus.req_vld = 1'b1;
    bus.req_pc  = 32'h4;
    bus.rsp_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_rdy !== 1'b0 || bus.rsp_vld !== 1'b0 || bus.rsp_ir !== '0 ||
        mem_cs !== 1'b0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b ir=%h cs=%b addr=%h want 0 0 0 0 0",
               bus.req_rdy, bus.rsp_vld, bus.rsp_ir, mem_cs, mem_addr);
    end
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    bus.req_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_rdy !== 1'b1 || bus.rsp_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b vld=%b want rdy=1 vld=0", bus.req_rdy, bus.rsp_vld);
    end
  endtask

  task automatic test_stream();
    logic exp_vld;
    for (int i = 0; i < 6; i++) begin
      drive(i < 3, AW'(i * 4), 1'b1);
      @(negedge clk);
      exp_vld = (i >= 1 && i <= 3);
      checks++;
      if (bus.rsp_vld !== exp_vld) begin
        errors++;
        $display("FAIL stream_rsp_vld[%0d]: got %b want %b", i, bus.rsp_vld, exp_vld);
      end
      if (i < 3) begin
        checks++;
        if (mem_cs !== 1'b1 || mem_addr !== AddrW'(i)) begin
          errors++;
          $display("FAIL stream_mem[%0d]: got cs=%b addr=%0d want cs=1 addr=%0d",
                   i, mem_cs, mem_addr, i);
        end
      end
      if (bus.rsp_vld && bus.rsp_rdy) begin
        exp_ir = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (bus.rsp_ir !== exp_ir) begin
          errors++;
          $display("FAIL stream_rsp_ir[%0d]: got %h want %h", i, bus.rsp_ir, exp_ir);
        end
      end
      note_req();
    end
  endtask

  task automatic test_low_bits();
    logic [AW-1:0] pcs [2] = '{32'h2, 32'h7};
    for (int i = 0; i < 4; i++) begin
      drive(i < 2, (i < 2) ? pcs[i] : '0, 1'b1);
      @(negedge clk);
      if (i < 2) begin
        checks++;
        if (mem_cs !== 1'b1 || mem_addr !== AddrW'(i)) begin
          errors++;
          $display("FAIL lowbits_addr[%0d]: got cs=%b addr=%0d want cs=1 addr=%0d",
                   i, mem_cs, mem_addr, i);
        end
      end
      if (bus.rsp_vld && bus.rsp_rdy) begin
        exp_ir = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (bus.rsp_ir !== exp_ir) begin
          errors++;
          $display("FAIL lowbits_rsp[%0d]: got %h want %h", i, bus.rsp_ir, exp_ir);
        end
      end
      note_req();
    end
  endtask

  task automatic test_out_of_range();
    logic [AW-1:0] pcs [2] = '{AW'(DEPTH * 4), 32'hFFFF_FFFC};
    for (int i = 0; i < 4; i++) begin
      drive(i < 2, (i < 2) ? pcs[i] : '0, 1'b1);
      @(negedge clk);
      if (i < 2) begin
        checks++;
        if (mem_cs !== 1'b0 || bus.req_rdy !== 1'b1) begin
          errors++;
          $display("FAIL oor_cs[%0d]: got cs=%b rdy=%b want cs=0 rdy=1", i, mem_cs, bus.req_rdy);
        end
      end
      if (i == 1 || i == 2) begin
        checks++;
        if (bus.rsp_vld !== 1'b1 || bus.rsp_ir !== 32'h0000_0013) begin
          errors++;
          $display("FAIL oor_nop[%0d]: got vld=%b ir=%h want vld=1 ir=00000013",
                   i, bus.rsp_vld, bus.rsp_ir);
        end
      end
      if (bus.rsp_vld && bus.rsp_rdy) begin
        exp_ir = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (bus.rsp_ir !== exp_ir) begin
          errors++;
          $display("FAIL oor_rsp[%0d]: got %h want %h", i, bus.rsp_ir, exp_ir);
        end
      end
      note_req();
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] pc = 32'h100;
    logic [DW-1:0] first = mem[32'h100 >> 2];
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, pc, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.req_rdy !== (i < 2)) begin
        errors++;
        $display("FAIL bp_req_rdy[%0d]: got %b want %b", i, bus.req_rdy, (i < 2));
      end
      if (i >= 1) begin
        checks++;
        if (bus.rsp_vld !== 1'b1 || bus.rsp_ir !== first) begin
          errors++;
          $display("FAIL bp_stable[%0d]: got vld=%b ir=%h want vld=1 ir=%h",
                   i, bus.rsp_vld, bus.rsp_ir, first);
        end
      end
      if (bus.req_rdy) pc = pc + 4;
      note_req();
    end
    checks++;
    if (exp_q.size() !== 2) begin
      errors++;
      $display("FAIL bp_accepted: got %0d want 2", exp_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1);
      @(negedge clk);
      if (bus.rsp_vld && bus.rsp_rdy) begin
        exp_ir = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (bus.rsp_ir !== exp_ir) begin
          errors++;
          $display("FAIL bp_drain[%0d]: got %h want %h", i, bus.rsp_ir, exp_ir);
        end
      end
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL bp_lost: got %0d outstanding want 0", exp_q.size());
    end
  endtask

  task automatic test_full_boundary();
    drive(1'b1, 32'h40, 1'b0);
    @(negedge clk);
    note_req();
    drive(1'b1, 32'h44, 1'b0);
    @(negedge clk);
    note_req();
    drive(1'b1, 32'h48, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.req_rdy !== 1'b0) begin
      errors++;
      $display("FAIL full_stall: got rdy=%b want 0", bus.req_rdy);
    end
    for (int i = 0; i < 7; i++) begin
      drive(i < 2, AW'(32'h48 + i * 4), 1'b1);
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (bus.req_rdy !== 1'b1 || mem_cs !== 1'b1 || bus.rsp_vld !== 1'b1) begin
          errors++;
          $display("FAIL full_pop_accept: got rdy=%b cs=%b vld=%b want 1 1 1",
                   bus.req_rdy, mem_cs, bus.rsp_vld);
        end
      end
      if (bus.rsp_vld && bus.rsp_rdy) begin
        exp_ir = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (bus.rsp_ir !== exp_ir) begin
          errors++;
          $display("FAIL full_order[%0d]: got %h want %h", i, bus.rsp_ir, exp_ir);
        end
      end
      note_req();
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL full_lost: got %0d outstanding want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(i < 2, AW'(32'h80 + i * 4), 1'b0);
      @(negedge clk);
      note_req();
    end
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    bus.req_vld = 1'b1;
    bus.rsp_rdy = 1'b1;
    #1;
    checks++;
    if (bus.rsp_vld !== 1'b0 || bus.req_rdy !== 1'b0 || bus.rsp_ir !== '0) begin
      errors++;
      $display("FAIL rstmid_async: got vld=%b rdy=%b ir=%h want 0 0 0",
               bus.rsp_vld, bus.req_rdy, bus.rsp_ir);
    end
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (mem_cs !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_cs: got %b want 0", mem_cs);
    end
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    bus.req_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_rdy !== 1'b1 || bus.rsp_vld !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_release: got rdy=%b vld=%b want 1 0", bus.req_rdy, bus.rsp_vld);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.rsp_vld !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_stale[%0d]: got vld=%b want 0", i, bus.rsp_vld);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] pc;
    logic          exp_rdy;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0) pc = AW'(DEPTH * 4) + AW'($urandom_range(0, 255) * 4);
      else pc = AW'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(0, 3));
      drive((i < 70) && ($urandom_range(0, 3) != 0), pc, (i >= 70) || ($urandom_range(0, 2) != 0));
      @(negedge clk);
      exp_rdy = (exp_q.size() < 2) || (bus.rsp_vld && bus.rsp_rdy);
      checks++;
      if (bus.req_rdy !== exp_rdy || bus.rsp_vld !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL b2b_flow[%0d]: got rdy=%b vld=%b want rdy=%b vld=%b",
                 i, bus.req_rdy, bus.rsp_vld, exp_rdy, (exp_q.size() != 0));
      end
      if (bus.rsp_vld && bus.rsp_rdy) begin
        exp_ir = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (bus.rsp_ir !== exp_ir) begin
          errors++;
          $display("FAIL b2b_rsp[%0d]: got %h want %h", i, bus.rsp_ir, exp_ir);
        end
      end
      note_req();
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL b2b_lost: got %0d outstanding want 0", exp_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    test_reset();
    test_stream();
    test_low_bits();
    test_out_of_range();
    test_backpressure();
    test_full_boundary();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 SHALL have parameter AW, default 32: fetch address width.
REQ-002 SHALL have parameter DW, default 32: instruction width.
REQ-003 SHALL have parameter DEPTH, default 1024: instruction SRAM depth in words, power of two.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port ifetch, ifetch_if_t.slave: req_vld/req_rdy/req_pc[AW] request channel and rsp_vld/rsp_rdy/rsp_ir[DW] response channel.
REQ-007 SHALL have port mem_cs, output, 1: SRAM read enable.
REQ-008 SHALL have port mem_addr, output, $clog2(DEPTH): SRAM word address.
REQ-009 SHALL have port mem_rdata, input, DW: SRAM read data, valid the cycle after mem_cs.

Function
REQ-010 SHALL treat a request handshake as req_vld & req_rdy and a response handshake as rsp_vld & rsp_rdy.
REQ-011 SHALL derive word index = req_pc[AW-1:2], ignoring req_pc[1:0].
REQ-012 SHALL, on an in-range request handshake (index < DEPTH) in cycle N, drive mem_cs=1 and mem_addr=index combinationally in cycle N.
REQ-013 SHALL, on an out-of-range request, keep mem_cs=0 and return the NOP value 32'h0000_0013 as that request's rsp_ir.
REQ-014 SHALL hold mem_cs=0 in every cycle without a request handshake.
REQ-015 SHALL present a response no earlier than cycle N+1: when the response buffer is empty, rsp_vld=1 in N+1 with rsp_ir=mem_rdata (or NOP) flow-through.
REQ-016 SHALL push the N+1 data into a 2-entry response FIFO when it is not consumed that cycle, or when older entries are still queued.
REQ-017 SHALL return responses strictly in request order.
REQ-018 SHALL keep an occupancy count = in-flight reads (0..1) + FIFO entries (0..2), never exceeding 2.
REQ-019 SHALL drive req_rdy = (occupancy < 2) | response handshake this cycle, so that 1 fetch/cycle is sustained when rsp_rdy is held high.
REQ-020 SHALL keep rsp_vld and rsp_ir stable while rsp_vld=1 and rsp_rdy=0.
REQ-021 SHALL, on simultaneous push and pop with a full FIFO, pop the head and push the new entry in the same cycle without loss.
REQ-022 SHALL wrap the FIFO read/write pointers modulo 2 with a separate full/empty flag.
REQ-023 SHALL make the next request's req_rdy independent of req_vld (no combinational req_vld->req_rdy path).

Reset
REQ-024 SHALL, during rst_n=0, force req_rdy=0, rsp_vld=0, rsp_ir=0, mem_cs=0, mem_addr=0, occupancy=0 and the FIFO empty.
REQ-025 SHALL discard any in-flight read or buffered response when reset is asserted mid-operation; no response appears after reset release.
REQ-026 SHALL assert req_rdy=1 in the first cycle after reset release.

Structure
REQ-027 SHALL place the NOP constant and an imem_rsp_t (ir) typedef in the shared core package.
REQ-028 SHALL implement the response buffer as one sub-module, resp_fifo2 (2-entry, same-cycle push/pop, registered outputs); the rest is inline.

Verification
REQ-029 SHALL cover streaming: rsp_rdy=1, requests pc=0x0,0x4,0x8 on back-to-back cycles -> mem_addr 0,1,2 on consecutive cycles; rsp_ir=mem[0],mem[1],mem[2] in cycles N+1..N+3.
REQ-030 SHALL cover backpressure: rsp_rdy=0 for 5 cycles while requests are issued -> req_rdy drops after 2 accepted; on rsp_rdy=1 both return in order, with no duplicates or losses.
REQ-031 SHALL cover out-of-range: pc=DEPTH*4 -> mem_cs=0; response 32'h0000_0013 at N+1.
REQ-032 SHALL cover low-bit ignore: pc=0x2 -> mem_addr=0 and rsp_ir=mem[0].
REQ-033 SHALL cover reset mid-operation: rst_n pulsed low with FIFO full -> rsp_vld=0 immediately; req_rdy=1 the first cycle after release; no stale response afterwards.
REQ-034 SHALL cover the full boundary: FIFO full, rsp_rdy and req_vld both high the same cycle -> pop and accept occur together; the sequence order is preserved.
